// File: rtl/rvtu_arb_pkg.sv
// Shared types and helpers for the DFP round-robin arbiters.
package rvtu_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    ADDR,
    WDATA,
    RDATA
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } dfp_op_t;

  // Bit width needed to index n items; never below 1 so single-item cases stay legal.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rvtu_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rvtu_rr_picker
  import rvtu_arb_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned IDX_W = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx
);

  logic [IDX_W-1:0] cand;
  logic             hit;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    hit  = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = IDX_W'((32'(ptr) + k) % NUM_CH);
      if (!hit && req[cand]) begin
        hit       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/rvtu_dfp_rr_arb.sv
// N-channel round-robin arbiter for the DFP request/ack/burst protocol.
// Owns one transaction at a time and steers read beats back to its owner.
module rvtu_dfp_rr_arb
  import rvtu_arb_pkg::*;
#(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_CH-1:0]              ch_read,
  input  logic [NUM_CH-1:0]              ch_write,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  ch_wdata,
  output logic [NUM_CH-1:0]              ch_ack,
  output logic [NUM_CH-1:0]              ch_rdata_valid,
  output logic [DATA_W-1:0]              ch_rdata,
  output logic                           mem_read,
  output logic                           mem_write,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic                           mem_ack,
  input  logic                           mem_rdata_valid,
  input  logic [DATA_W-1:0]              mem_rdata,
  output logic                           busy,
  output logic [$clog2(NUM_CH)-1:0]      owner,
  output logic                           err_stray_rdata
);

  localparam int unsigned OW = clog2_min1(NUM_CH);
  localparam int unsigned BW = clog2_min1(BURST_LEN + 1);

  arb_state_t      state_q, state_d;
  dfp_op_t         op_q, op_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            err_q, err_d;

  logic [NUM_CH-1:0] pick_gnt;
  logic [OW-1:0]     pick_idx;

  rvtu_rr_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .req (ch_read | ch_write),
    .ptr (rr_ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q | (mem_rdata_valid && (state_q != RDATA));
    case (state_q)
      IDLE: begin
        if (|pick_gnt) begin
          owner_d  = pick_idx;
          // a channel raising both read and write is treated as a read
          op_d     = (|(pick_gnt & ch_read)) ? OP_READ : OP_WRITE;
          rr_ptr_d = (pick_idx == OW'(NUM_CH - 1)) ? '0 : pick_idx + OW'(1);
          state_d  = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          beat_cnt_d = '0;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        beat_cnt_d = '0;
        state_d    = (op_q == OP_WRITE) ? WDATA : RDATA;
      end
      WDATA: begin
        if (beat_cnt_q == BW'(BURST_LEN - 1)) begin
          state_d = IDLE;
        end else begin
          beat_cnt_d = beat_cnt_q + BW'(1);
        end
      end
      RDATA: begin
        if (mem_rdata_valid) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (beat_cnt_q == BW'(BURST_LEN - 1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy           = (state_q != IDLE);
    mem_read       = (state_q == REQ) && (op_q == OP_READ);
    mem_write      = (state_q == REQ) && (op_q == OP_WRITE);
    ch_ack         = '0;
    ch_rdata_valid = '0;
    ch_rdata       = mem_rdata;
    mem_wdata      = '0;
    if ((state_q == REQ) && mem_ack) begin
      ch_ack[owner_q] = 1'b1;
    end
    if ((state_q == ADDR) || (state_q == WDATA)) begin
      mem_wdata = ch_wdata[owner_q];
    end
    if ((state_q == RDATA) && mem_rdata_valid) begin
      ch_rdata_valid[owner_q] = 1'b1;
    end
    owner           = owner_q;
    err_stray_rdata = err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_READ;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_rvtu_dfp_rr_arb.sv
// Bench for rvtu_dfp_rr_arb: a 4-channel/4-beat instance and a 2-channel/1-beat
// instance, each checked every cycle against a transaction-level model.
module tb_rvtu_dfp_rr_arb;

  typedef struct {
    bit active;
    bit acked;
    bit addr_sent;
    bit rd;
    bit err;
    int beats_left;
    int own;
    int nxt;
  } mdl_t;

  typedef struct {
    int cnt;
    int beats;
    int cd;
    int seq;
    bit acked;
  } mem_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]       a_rd = '0, a_wr = '0, a_rep_rd = '0, a_rep_wr = '0;
  logic [3:0][31:0] a_wdata = '0;
  logic [3:0]       a_ack, a_rv;
  logic [31:0]      a_rdata, a_mwdata;
  logic             a_mrd, a_mwr, a_busy, a_err;
  logic             a_mack = 1'b0, a_mrv = 1'b0;
  logic [31:0]      a_mrdata = '0;
  logic [1:0]       a_owner;

  logic [1:0]       b_rd = '0, b_wr = '0, b_rep_rd = '0;
  logic [1:0][31:0] b_wdata = '0;
  logic [1:0]       b_ack, b_rv;
  logic [31:0]      b_rdata, b_mwdata;
  logic             b_mrd, b_mwr, b_busy, b_err;
  logic             b_mack = 1'b0, b_mrv = 1'b0;
  logic [31:0]      b_mrdata = '0;
  logic [0:0]       b_owner;

  rvtu_dfp_rr_arb #(.NUM_CH(4), .DATA_W(32), .BURST_LEN(4)) u_a (
    .clk(clk), .rst_n(rst_n), .ch_read(a_rd), .ch_write(a_wr), .ch_wdata(a_wdata),
    .ch_ack(a_ack), .ch_rdata_valid(a_rv), .ch_rdata(a_rdata),
    .mem_read(a_mrd), .mem_write(a_mwr), .mem_wdata(a_mwdata), .mem_ack(a_mack),
    .mem_rdata_valid(a_mrv), .mem_rdata(a_mrdata), .busy(a_busy), .owner(a_owner),
    .err_stray_rdata(a_err));

  rvtu_dfp_rr_arb #(.NUM_CH(2), .DATA_W(32), .BURST_LEN(1)) u_b (
    .clk(clk), .rst_n(rst_n), .ch_read(b_rd), .ch_write(b_wr), .ch_wdata(b_wdata),
    .ch_ack(b_ack), .ch_rdata_valid(b_rv), .ch_rdata(b_rdata),
    .mem_read(b_mrd), .mem_write(b_mwr), .mem_wdata(b_mwdata), .mem_ack(b_mack),
    .mem_rdata_valid(b_mrv), .mem_rdata(b_mrdata), .busy(b_busy), .owner(b_owner),
    .err_stray_rdata(b_err));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;
  mdl_t m_a, m_b;
  mem_t mem_a, mem_b;
  int a_dly = 1, a_per = 1, b_dly = 1, b_per = 1;
  logic [31:0] a_rbase = 32'h0, b_rbase = 32'h0;
  int a_grants[$], b_grants[$];
  logic [31:0] a_rdq[$];
  int a_rv_cnt[4];
  int b_rv_cnt[2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // Transaction-level view: a grant opens a transaction, an ack closes the request
  // phase, one address beat follows, then the burst drains (reads only on valid).
  function automatic mdl_t mdl_next(mdl_t m, int nch, int blen, logic rstn,
                                    logic [3:0] rq, logic [3:0] rdv, logic mack, logic mrv);
    mdl_t n = m;
    bit hit = 1'b0;
    if (!rstn) begin
      n = '{default: 0};
      return n;
    end
    if (mrv && !(m.active && m.addr_sent && m.rd)) n.err = 1'b1;
    if (!m.active) begin
      for (int k = 0; k < nch; k++) begin
        int c = (m.nxt + k) % nch;
        if (!hit && rq[c]) begin
          hit = 1'b1;
          n.active = 1'b1; n.acked = 1'b0; n.addr_sent = 1'b0;
          n.own = c; n.rd = rdv[c]; n.nxt = (c + 1) % nch; n.beats_left = blen;
        end
      end
    end else if (!m.acked) begin
      if (mack) n.acked = 1'b1;
    end else if (!m.addr_sent) begin
      n.addr_sent = 1'b1;
    end else if (!m.rd || mrv) begin
      n.beats_left = m.beats_left - 1;
      if (n.beats_left == 0) n.active = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m_a <= mdl_next(m_a, 4, 4, rst_n, a_rd | a_wr, a_rd, a_mack, a_mrv);
    m_b <= mdl_next(m_b, 2, 1, rst_n, {2'b00, b_rd | b_wr}, {2'b00, b_rd}, b_mack, b_mrv);
  end

  task automatic check_dut(input string t, input mdl_t m, input logic [3:0] ack, rv,
                           input logic mrd, mwr, input logic [31:0] mwd, rdata,
                           input logic [1:0] own, input logic busy, err, mack, mrv,
                           input logic [31:0] mrdata, wsel);
    logic [3:0] e_ack = '0;
    logic [3:0] e_rv = '0;
    logic [31:0] e_wd = '0;
    if (m.active && !m.acked && mack) e_ack[m.own] = 1'b1;
    if (m.active && m.addr_sent && m.rd && mrv) e_rv[m.own] = 1'b1;
    if (m.active && m.acked && (!m.addr_sent || !m.rd)) e_wd = wsel;
    chk({t, ".busy"}, busy, m.active);
    chk({t, ".mem_read"}, mrd, m.active && !m.acked && m.rd);
    chk({t, ".mem_write"}, mwr, m.active && !m.acked && !m.rd);
    chk({t, ".ch_ack"}, ack, e_ack);
    chk({t, ".rdata_valid"}, rv, e_rv);
    chk({t, ".mem_wdata"}, mwd, e_wd);
    chk({t, ".ch_rdata"}, rdata, mrdata);
    chk({t, ".owner"}, own, m.own);
    chk({t, ".err"}, err, m.err);
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check_dut("a", m_a, a_ack, a_rv, a_mrd, a_mwr, a_mwdata, a_rdata, a_owner, a_busy,
                a_err, a_mack, a_mrv, a_mrdata, a_wdata[m_a.own]);
      check_dut("b", m_b, {2'b00, b_ack}, {2'b00, b_rv}, b_mrd, b_mwr, b_mwdata, b_rdata,
                {1'b0, b_owner}, b_busy, b_err, b_mack, b_mrv, b_mrdata, b_wdata[m_b.own]);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int c = 0; c < 4; c++) begin
        if (a_ack[c]) a_grants.push_back(c);
        if (a_rv[c]) begin
          a_rv_cnt[c]++;
          a_rdq.push_back(a_rdata);
        end
      end
      for (int c = 0; c < 2; c++) begin
        if (b_ack[c]) b_grants.push_back(c);
        if (b_rv[c]) b_rv_cnt[c]++;
      end
    end
  end

  // Downstream responder: ack after dly REQ cycles, skip the address beat, then
  // deliver read beats one every per cycles.
  task automatic mem_step(inout mem_t s, input logic rs, req, rd, input int dly, per, blen,
                          input logic [31:0] base, output logic ack, rv, output logic [31:0] data);
    ack = 1'b0; rv = 1'b0; data = '0;
    if (!rs) begin
      s = '{default: 0};
      return;
    end
    if (s.acked) begin
      s.acked = 1'b0; s.cnt = 0; s.beats = rd ? blen : 0; s.cd = per - 1; s.seq = 0;
    end else if (s.beats > 0) begin
      if (s.cd == 0) begin
        rv = 1'b1; data = base + 32'(s.seq); s.seq++; s.beats--; s.cd = per - 1;
      end else begin
        s.cd--;
      end
    end else if (req) begin
      s.cnt++;
      if (s.cnt >= dly) begin
        ack = 1'b1; s.acked = 1'b1;
      end
    end
  endtask

  task automatic step();
    logic [3:0] aack;
    logic [1:0] back;
    logic arq, ard, brq, brd, rs;
    @(negedge clk);
    aack = a_ack; back = b_ack; rs = rst_n;
    arq = a_mrd | a_mwr; ard = a_mrd; brq = b_mrd | b_mwr; brd = b_mrd;
    @(posedge clk);
    #1;
    cyc++;
    a_rd = (a_rd | a_rep_rd) & ~aack;
    a_wr = (a_wr | a_rep_wr) & ~aack;
    b_rd = (b_rd | b_rep_rd) & ~back;
    b_wr = b_wr & ~back;
    for (int c = 0; c < 4; c++) a_wdata[c] = 32'hC000_0000 | (32'(c) << 20) | (32'(cyc) & 32'hFFFF);
    for (int c = 0; c < 2; c++) b_wdata[c] = 32'hB000_0000 | (32'(c) << 20) | (32'(cyc) & 32'hFFFF);
    mem_step(mem_a, rs, arq, ard, a_dly, a_per, 4, a_rbase, a_mack, a_mrv, a_mrdata);
    mem_step(mem_b, rs, brq, brd, b_dly, b_per, 1, b_rbase, b_mack, b_mrv, b_mrdata);
  endtask

  task automatic clear_obs();
    a_grants.delete(); b_grants.delete(); a_rdq.delete();
    for (int c = 0; c < 4; c++) a_rv_cnt[c] = 0;
    for (int c = 0; c < 2; c++) b_rv_cnt[c] = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_rd = '0; a_wr = '0; a_rep_rd = '0; a_rep_wr = '0;
    b_rd = '0; b_wr = '0; b_rep_rd = '0;
    step();
    step();
    rst_n = 1'b1;
    cmp_en = 1'b1;
    clear_obs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst.busy", a_busy, 1'b0);
    chk("rst.owner", a_owner, 2'd0);
    chk("rst.err", a_err, 1'b0);
    chk("rst.mem_req", {a_mrd, a_mwr}, 2'b00);
    chk("rst.mem_wdata", a_mwdata, 32'h0);

    // single read from channel 1, ack three cycles into REQ
    a_dly = 3; a_per = 1; a_rbase = 32'hA0;
    a_rd = 4'b0010;
    for (int i = 0; i < 60 && a_rv_cnt[1] < 4; i++) step();
    chk("t1.beats_ch1", a_rv_cnt[1], 4);
    chk("t1.beats_other", a_rv_cnt[0] + a_rv_cnt[2] + a_rv_cnt[3], 0);
    chk("t1.busy_after", a_busy, 1'b0);
    chk("t1.owner", a_owner, 2'd1);
    chk("t1.ngrants", a_grants.size(), 1);
    if (a_grants.size() > 0) chk("t1.grant", a_grants[0], 1);
    chk("t1.nrdata", a_rdq.size(), 4);
    for (int i = 0; i < 4 && i < a_rdq.size(); i++) chk("t1.rdata", a_rdq[i], 32'hA0 + 32'(i));

    // all four channels write continuously
    do_reset();
    a_dly = 1;
    a_wr = 4'hF; a_rep_wr = 4'hF;
    for (int i = 0; i < 300 && a_grants.size() < 5; i++) step();
    a_rep_wr = '0; a_wr = '0;
    for (int i = 0; i < 50 && a_busy; i++) step();
    chk("t2.idle", a_busy, 1'b0);
    chk("t2.ngrants", a_grants.size() >= 5, 1'b1);
    if (a_grants.size() >= 5) begin
      chk("t2.g0", a_grants[0], 0);
      chk("t2.g1", a_grants[1], 1);
      chk("t2.g2", a_grants[2], 2);
      chk("t2.g3", a_grants[3], 3);
      chk("t2.g4", a_grants[4], 0);
    end

    // read and write together on channel 2: read wins
    do_reset();
    a_dly = 2; a_rbase = 32'h50;
    a_rd[2] = 1'b1; a_wr[2] = 1'b1;
    for (int i = 0; i < 10 && !a_busy; i++) step();
    chk("t3.mem_read", a_mrd, 1'b1);
    chk("t3.mem_write", a_mwr, 1'b0);
    chk("t3.owner", a_owner, 2'd2);
    for (int i = 0; i < 60 && a_rv_cnt[2] < 4; i++) step();
    chk("t3.beats_ch2", a_rv_cnt[2], 4);
    chk("t3.beats_other", a_rv_cnt[0] + a_rv_cnt[1] + a_rv_cnt[3], 0);
    chk("t3.busy_after", a_busy, 1'b0);

    // stray read data in IDLE and in WDATA
    do_reset();
    a_dly = 1;
    step();
    a_mrv = 1'b1; a_mrdata = 32'hDEAD_0001;
    step();
    chk("t4.err_idle", a_err, 1'b1);
    a_wr[0] = 1'b1;
    for (int i = 0; i < 20 && !(m_a.active && m_a.addr_sent && !m_a.rd); i++) step();
    a_mrv = 1'b1; a_mrdata = 32'hDEAD_0002;
    step();
    for (int i = 0; i < 20 && a_busy; i++) step();
    chk("t4.err_sticky", a_err, 1'b1);
    chk("t4.no_valid", a_rv_cnt[0] + a_rv_cnt[1] + a_rv_cnt[2] + a_rv_cnt[3], 0);

    // reset on the second write beat, then ptr must be back at channel 0
    do_reset();
    a_dly = 1;
    a_wr[0] = 1'b1;
    for (int i = 0; i < 20 && !(m_a.active && m_a.addr_sent && m_a.beats_left == 3); i++) step();
    chk("t5.in_beat2", a_mwdata != 32'h0, 1'b1);
    rst_n = 1'b0;
    a_wr = '0;
    step();
    rst_n = 1'b1;
    chk("t5.busy", a_busy, 1'b0);
    chk("t5.mem_wdata", a_mwdata, 32'h0);
    chk("t5.owner", a_owner, 2'd0);
    clear_obs();
    a_wr = 4'b1001;
    for (int i = 0; i < 60 && !(a_grants.size() >= 2 && !a_busy); i++) step();
    chk("t5.ngrants", a_grants.size(), 2);
    if (a_grants.size() >= 2) begin
      chk("t5.first", a_grants[0], 0);
      chk("t5.ch3", a_grants[1], 3);
    end

    // two-channel single-beat instance, reads with long gaps
    do_reset();
    b_dly = 1; b_per = 6; b_rbase = 32'h77;
    b_rd = 2'b11; b_rep_rd = 2'b11;
    for (int i = 0; i < 400 && b_grants.size() < 4; i++) step();
    b_rep_rd = '0; b_rd = '0;
    for (int i = 0; i < 50 && b_busy; i++) step();
    chk("t6.idle", b_busy, 1'b0);
    chk("t6.ngrants", b_grants.size(), 4);
    if (b_grants.size() >= 4) begin
      chk("t6.g0", b_grants[0], 0);
      chk("t6.g1", b_grants[1], 1);
      chk("t6.g2", b_grants[2], 0);
      chk("t6.g3", b_grants[3], 1);
    end
    chk("t6.beats_ch0", b_rv_cnt[0], 2);
    chk("t6.beats_ch1", b_rv_cnt[1], 2);

    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
